// File: rtl/flash_resp_pkg.sv
// flash_resp_pkg: opcodes, status bits and state encodings
// shared by the NOR flash emulator files.
package flash_resp_pkg;

  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_CLEAR_SR    = 8'h50;
  localparam logic [7:0] CMD_PROG        = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
  localparam logic [7:0] CMD_ERASE       = 8'h20;
  localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG_SETUP,
    ST_PROG_BUSY,
    ST_ERASE_SETUP,
    ST_ERASE_BUSY
  } state_e;

  typedef enum logic {
    MODE_ARRAY,
    MODE_STATUS
  } mode_e;

  function automatic logic [15:0] status_word(
    input logic ready,
    input logic erase_err,
    input logic prog_err
  );
    logic [7:0] sr;
    sr = '0;
    sr[SR_READY]     = ready;
    sr[SR_ERASE_ERR] = erase_err;
    sr[SR_PROG_ERR]  = prog_err;
    return {8'h00, sr};
  endfunction

endpackage

// File: rtl/flash_resp_mem.sv
// flash_resp_mem: 2^AW x 16 single-port RAM, 1-cycle read,
// write port shared by program and erase.
module flash_resp_mem #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [2**AW];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/flash_resp.sv
// flash_resp: 16-bit NOR flash emulator on the ce_n/oe_n/we_n bus.
// Block erase is built only when FLASH_RESP_ERASE_EN is defined.
module flash_resp
  import flash_resp_pkg::*;
#(
  parameter int AW           = 12,
  parameter int BLK_AW       = 8,
  parameter int READ_LAT     = 2,
  parameter int PROG_CYCLES  = 16,
  parameter int ERASE_CYCLES = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] addr,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  input  logic        ce_n,
  input  logic        oe_n,
  input  logic        we_n,
  output logic        rdybsy_n
);

  localparam int BLK_WORDS = 1 << BLK_AW;
  localparam int ERASE_EFF =
    (ERASE_CYCLES > BLK_WORDS + 1) ? ERASE_CYCLES : BLK_WORDS + 1;
  localparam int CNT_MAX =
    (ERASE_EFF > PROG_CYCLES) ? ERASE_EFF : PROG_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic              sr5_q, sr5_d;
  logic              sr4_q, sr4_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     pa_q, pa_d;
  logic [15:0]       pd_q, pd_d;
  logic [AW-1:0]     wa_q, wa_d;
  logic [15:0]       wd_q, wd_d;
  logic              we_s_q, ce_s_q;
  logic              commit_q, commit_d;
  logic              rd_s_q, rd_s_d;
  logic              dq_oe_q;
  logic              rdy_q, rdy_d;
  logic [READ_LAT-1:0][15:0] pipe_q, pipe_d;
`ifdef FLASH_RESP_ERASE_EN
  logic [AW-BLK_AW-1:0] eb_q, eb_d;
`endif

  logic [AW-1:0] mem_a;
  logic          mem_we;
  logic [15:0]   mem_wd;
  logic [15:0]   rdata;
  logic [15:0]   rd_word;
  logic          unused_hi;

  assign unused_hi = ^addr[23:AW];

  flash_resp_mem #(
    .AW(AW)
  ) u_mem (
    .clk  (clk),
    .addr (mem_a),
    .we   (mem_we),
    .wdata(mem_wd),
    .rdata(rdata)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    sr5_d    = sr5_q;
    sr4_d    = sr4_q;
    cnt_d    = cnt_q;
    pa_d     = pa_q;
    pd_d     = pd_q;
    wa_d     = wa_q;
    wd_d     = wd_q;
`ifdef FLASH_RESP_ERASE_EN
    eb_d     = eb_q;
`endif
    mem_a    = addr[AW-1:0];
    mem_we   = 1'b0;
    mem_wd   = pd_q & rdata;

    // Commit is acted on one edge after the we_n rising sample.
    commit_d = !ce_n && we_n && !ce_s_q && !we_s_q;
    rd_s_d   = !ce_n && !oe_n && we_n;
    if (!ce_n && !we_n) begin
      wa_d = addr[AW-1:0];
      wd_d = dq_i;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (commit_q) begin
          unique case (wd_q[7:0])
            CMD_READ_ARRAY:  mode_d = MODE_ARRAY;
            CMD_READ_STATUS: mode_d = MODE_STATUS;
            CMD_CLEAR_SR: begin
              sr5_d = 1'b0;
              sr4_d = 1'b0;
            end
            CMD_PROG, CMD_PROG_ALT: state_d = ST_PROG_SETUP;
            CMD_ERASE: begin
`ifdef FLASH_RESP_ERASE_EN
              state_d = ST_ERASE_SETUP;
`else
              sr5_d  = 1'b1;
              mode_d = MODE_STATUS;
`endif
            end
            default: ;
          endcase
        end
      end
      ST_PROG_SETUP: begin
        mem_a = wa_q;
        if (commit_q) begin
          pa_d    = wa_q;
          pd_d    = wd_q;
          cnt_d   = '0;
          state_d = ST_PROG_BUSY;
          mode_d  = MODE_STATUS;
        end
      end
      ST_PROG_BUSY: begin
        mem_a = pa_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(PROG_CYCLES - 1)) begin
          mem_we  = 1'b1;
          state_d = ST_IDLE;
          if (|(pd_q & ~rdata)) sr4_d = 1'b1;
        end
      end
`ifdef FLASH_RESP_ERASE_EN
      ST_ERASE_SETUP: begin
        if (commit_q) begin
          mode_d = MODE_STATUS;
          if (wd_q[7:0] == CMD_CONFIRM) begin
            eb_d    = wa_q[AW-1:BLK_AW];
            cnt_d   = '0;
            state_d = ST_ERASE_BUSY;
          end else begin
            sr5_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERASE_BUSY: begin
        mem_a  = {eb_q, cnt_q[BLK_AW-1:0]};
        mem_wd = 16'hFFFF;
        mem_we = cnt_q < CW'(BLK_WORDS);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(ERASE_EFF - 1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    rdy_d = !(state_d == ST_PROG_BUSY || state_d == ST_ERASE_BUSY);

    rd_word = rdata;
    if (mode_q == MODE_STATUS || state_q != ST_IDLE)
      rd_word = status_word(state_q == ST_IDLE, sr5_q, sr4_q);

    pipe_d[0] = rd_word;
    for (int i = 1; i < READ_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_ARRAY;
      sr5_q    <= 1'b0;
      sr4_q    <= 1'b0;
      cnt_q    <= '0;
      pa_q     <= '0;
      pd_q     <= '0;
      wa_q     <= '0;
      wd_q     <= '0;
      we_s_q   <= 1'b1;
      ce_s_q   <= 1'b1;
      commit_q <= 1'b0;
      rd_s_q   <= 1'b0;
      dq_oe_q  <= 1'b0;
      rdy_q    <= 1'b1;
      pipe_q   <= '0;
`ifdef FLASH_RESP_ERASE_EN
      eb_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      sr5_q    <= sr5_d;
      sr4_q    <= sr4_d;
      cnt_q    <= cnt_d;
      pa_q     <= pa_d;
      pd_q     <= pd_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      we_s_q   <= we_n;
      ce_s_q   <= ce_n;
      commit_q <= commit_d;
      rd_s_q   <= rd_s_d;
      dq_oe_q  <= rd_s_q;
      rdy_q    <= rdy_d;
      pipe_q   <= pipe_d;
`ifdef FLASH_RESP_ERASE_EN
      eb_q     <= eb_d;
`endif
    end
  end

  assign dq_o     = pipe_q[READ_LAT-1];
  assign dq_oe    = dq_oe_q;
  assign rdybsy_n = rdy_q;

endmodule
